// File: rtl/led_fade_driver.sv
// PWM LED output stage: each channel's level ramps linearly toward its target
// brightness, with a bypass mode and a selectable pin polarity.
module led_fade_driver #(
  parameter int CHANNELS         = 8,
  parameter int PWM_BITS         = 8,
  parameter int FADE_STEP_CYCLES = 1024,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] led_i,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                enable,
  output logic [CHANNELS-1:0] led_o,
  output logic                busy
);

  localparam int TICK_W = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  // PWM wraps one short of full scale so the top level is lit on every cycle.
  localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(FADE_STEP_CYCLES - 1);
  localparam logic                POL       = (ACTIVE_LOW != 0);

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic [PWM_BITS-1:0] level_r  [CHANNELS];
  logic [PWM_BITS-1:0] target_s [CHANNELS];
  logic [CHANNELS-1:0] lit_s;
  logic                busy_s;
  logic                step_s;

  // Targets, lit decision and level/target mismatch for every channel.
  always_comb begin
    step_s = (tick_cnt_r == TICK_LAST);
    lit_s  = {CHANNELS{1'b0}};
    busy_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      target_s[i] = led_i[i] ? brightness : {PWM_BITS{1'b0}};
      if (enable) begin
        lit_s[i] = (pwm_cnt_r < level_r[i]);
      end else begin
        lit_s[i] = led_i[i];
      end
      busy_s = busy_s | (level_r[i] != target_s[i]);
    end
  end

  // Free-running PWM and fade tick counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_cnt_r  <= {PWM_BITS{1'b0}};
      tick_cnt_r <= {TICK_W{1'b0}};
    end else begin
      if (pwm_cnt_r == PWM_LAST) begin
        pwm_cnt_r <= {PWM_BITS{1'b0}};
      end else begin
        pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      end
      if (step_s) begin
        tick_cnt_r <= {TICK_W{1'b0}};
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end
    end
  end

  // Level ramp: one unit toward target per step; frozen in bypass.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!reset) begin
        level_r[i] <= {PWM_BITS{1'b0}};
      end else if (step_s && enable) begin
        if (level_r[i] < target_s[i]) begin
          level_r[i] <= level_r[i] + PWM_BITS'(1);
        end else if (level_r[i] > target_s[i]) begin
          level_r[i] <= level_r[i] - PWM_BITS'(1);
        end else begin
          level_r[i] <= level_r[i];
        end
      end else begin
        level_r[i] <= level_r[i];
      end
    end
  end

  // Registered pin drive and busy flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_o <= {CHANNELS{POL}};
      busy  <= 1'b0;
    end else begin
      led_o <= lit_s ^ {CHANNELS{POL}};
      busy  <= busy_s & enable;
    end
  end

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Output stage between the SoC `leds` bus and the board LED pins. Each SoC LED bit becomes a PWM-driven pin whose brightness ramps linearly toward its target instead of switching abruptly. A global brightness ceiling, a bypass mode and a pin-polarity option suit active-low board LEDs. Instantiated in the board top between `Grande_Risco_5_SOC.leds` and the `led` pins.

## Interface
- `CHANNELS`, 8, number of LED channels
- `PWM_BITS`, 8, width of level, brightness and PWM counter
- `FADE_STEP_CYCLES`, 1024, clock cycles between level steps; legal range 1 to 2^20
- `ACTIVE_LOW`, 1, 1 = pin driven 0 when LED lit

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `led_i`  in  CHANNELS  LED request bits from the SoC (1 = lit)
- `brightness`  in  PWM_BITS  ceiling level for lit channels
- `enable`  in  1  1 = fade/PWM mode, 0 = bypass
- `led_o`  out  CHANNELS  registered pin drive, polarity per ACTIVE_LOW
- `busy`  out  1  registered; 1 while any channel level differs from its target

## Operation
- **PWM counter `pwm_cnt`**
  - Counts 0 to 2^PWM_BITS−2, then wraps to 0.
  - Period is 255 cycles for PWM_BITS=8.
  - It runs regardless of `enable`.
- **Tick counter**
  - Counts 0 to FADE_STEP_CYCLES−1 and produces a one-cycle `step` pulse on wrap.
  - FADE_STEP_CYCLES=1 gives `step` every cycle.
  - It runs regardless of `enable`.
- **Per-channel target**
  - `target[i]` = `led_i[i]` ? `brightness` : 0.
  - Evaluated combinationally each cycle.
- **Per-channel level register `level[i]`** (PWM_BITS wide)
  - Updated only on a `step` cycle while `enable`=1.
  - If level < target: +1. If level > target: −1. Otherwise hold.
  - No overflow or underflow is possible because the target lies within 0 to 2^PWM_BITS−1.
- **Per-channel state**, derived, not stored separately:
  - OFF: level = 0 and target = 0.
  - RISING: level < target.
  - ON: level = target ≠ 0.
  - FALLING: level > target.
  - A change in `led_i` or `brightness` mid-ramp reverses or extends the ramp from the current level. There is no restart from 0.
- **Lit condition**
  - `lit[i]` = (`pwm_cnt` < `level[i]`).
  - Level 0 is never lit.
  - Level 2^PWM_BITS−1 is always lit.
- **Bypass, `enable`=0**
  - `lit[i]` = `led_i[i]`.
  - Levels freeze at their current values.
  - On return to `enable`=1, ramping resumes from the frozen levels.
- **Pin drive**
  - `led_o[i]` = `lit[i]` XOR `ACTIVE_LOW`, registered.
- **Busy**
  - `busy` = OR over channels of (level ≠ target), registered.
  - `busy` is forced 0 while `enable`=0.

## Timing
- **Reset** (`reset`=0 sampled at a rising edge of `clk`):
  - `pwm_cnt` = 0, tick counter = 0, all levels = 0.
  - `led_o` = all pins off: all ones if ACTIVE_LOW, else all zeros.
  - `busy` = 0.
- **Reset mid-ramp**: all levels return to 0 on the next edge. No fade-out.
- **Latency**:
  - `led_i` to `led_o` in bypass: 1 cycle.
  - `pwm_cnt`/`level` to `led_o`: 1 cycle.
  - A target change is visible on `busy` 1 cycle later.
- **Fade time**: a ramp from 0 to B takes B × FADE_STEP_CYCLES cycles, ±FADE_STEP_CYCLES of phase.
- **First step after reset** occurs on cycle FADE_STEP_CYCLES after reset release.
- **Simultaneous events**:
  - A target change on a `step` cycle uses the new target for that step.
  - If `enable` falls on a `step` cycle, the step is suppressed.
- **Duty**: level L in fade mode gives exactly L lit cycles per 255-cycle PWM period (PWM_BITS=8), steady state.

## Test plan
1. **Reset**
   - Stimulus: ACTIVE_LOW=1; hold `reset`=0 for 5 cycles with `led_i`=8'hFF.
   - Required: `led_o`=8'hFF and `busy`=0 throughout.
   - Required: one cycle after release, all levels are still 0.
2. **Bypass**
   - Stimulus: `enable`=0; drive `led_i`=8'hA5.
   - Required: `led_o`=8'h5A one cycle later.
   - Required: `busy`=0 and levels unchanged.
3. **Full ramp-up**
   - Stimulus: FADE_STEP_CYCLES=4, `brightness`=8'hFF, `enable`=1; `led_i` 0 to 8'h01.
   - Required: level[0] reaches 255 after 255 steps (1020 ±4 cycles).
   - Required: `busy` falls 1 cycle after the final step.
   - Required: `led_o[0]` then stays at 0 (lit) continuously.
4. **Duty check**
   - Stimulus: level[0] settled at 8'h40.
   - Required: over any 255-cycle window, `led_o[0]` is low for exactly 64 cycles.
5. **Mid-ramp reversal**
   - Stimulus: FADE_STEP_CYCLES=1; ramp channel 3 to level 100; drop `led_i[3]`.
   - Required: level decrements 100 to 0 over 100 cycles, without jumping.
   - Required: `busy` falls at 0.
   - Required: a `brightness` change from 200 to 50 while ON makes the level fall to 50.
6. **Freeze and resume**
   - Stimulus: ramping channel at level 30; `enable`=0 for 500 cycles, then `enable`=1.
   - Required: level holds 30 during bypass.
   - Required: ramping resumes at 31 on the first subsequent step.
